// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART blocks: FSM states,
// oversampling constants and small bit-level helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int         OS_RATE        = 16;
    localparam logic [3:0] OS_LAST        = 4'(OS_RATE - 1);
    localparam logic [3:0] SMP_A          = 4'd7;
    localparam logic [3:0] SMP_B          = 4'd8;
    localparam logic [3:0] SMP_C          = 4'd9;
    localparam int         DEFAULT_OS_DIV = 833;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle enable every OS_DIV clocks, so all
// UART logic stays on clk_16MHz.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int OS_DIV = DEFAULT_OS_DIV
) (
    input  logic clk_16MHz,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW       = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OS_DIV - 1);

    logic [CW-1:0] cnt_r;

    // free-running divider, wraps on the tick cycle
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            cnt_r <= CW'(0);
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CW'(0);
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver (8 data bits, optional parity, 1 stop bit)
// with valid/ack byte output and framing/parity/overrun pulses.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int OS_DIV     = DEFAULT_OS_DIV,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_16MHz,
    input  logic       rst_n,
    input  logic       ser_data_frm_pc,
    input  logic       dout_ack,
    output logic [7:0] dout_byte,
    output logic       dout_vld,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    rx_state_e  state_r, state_next_s;
    logic       sync1_r, sync2_r;
    logic       tick_s, line_s, bit_val_s;
    logic       smp_a_r, smp_b_r;
    logic [3:0] os_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       par_ok_r;
    logic       stop_done_s, parity_ok_s, deliver_s;

    uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
        .clk_16MHz (clk_16MHz),
        .rst_n     (rst_n),
        .tick      (tick_s)
    );

    // two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= ser_data_frm_pc;
            sync2_r <= sync1_r;
        end
    end

    assign line_s      = sync2_r;
    assign bit_val_s   = maj3(smp_a_r, smp_b_r, line_s);
    assign parity_ok_s = PARITY_EN ? par_ok_r : 1'b1;
    assign deliver_s   = stop_done_s & bit_val_s & parity_ok_s;

    // state register
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic; every transition is qualified by the oversample tick
    always_comb begin
        state_next_s = state_r;
        stop_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s && !line_s) state_next_s = START;
                else                   state_next_s = state_r;
            end
            START: begin
                if (tick_s && os_cnt_r == SMP_C && bit_val_s) state_next_s = IDLE;
                else if (tick_s && os_cnt_r == OS_LAST)       state_next_s = DATA;
                else                                          state_next_s = state_r;
            end
            DATA: begin
                if (tick_s && os_cnt_r == OS_LAST && bit_cnt_r == 3'd7)
                    state_next_s = PARITY_EN ? PARITY : STOP;
                else
                    state_next_s = state_r;
            end
            PARITY: begin
                if (tick_s && os_cnt_r == OS_LAST) state_next_s = STOP;
                else                               state_next_s = state_r;
            end
            STOP: begin
                // leave at mid-stop so a back-to-back start edge is not missed
                if (tick_s && os_cnt_r == SMP_C) begin
                    stop_done_s  = 1'b1;
                    state_next_s = bit_val_s ? IDLE : BREAK;
                end else begin
                    state_next_s = state_r;
                end
            end
            BREAK: begin
                if (tick_s && line_s) state_next_s = IDLE;
                else                  state_next_s = state_r;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // sample counters, majority samples, shift register and parity check
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            os_cnt_r  <= 4'd0;
            bit_cnt_r <= 3'd0;
            smp_a_r   <= 1'b1;
            smp_b_r   <= 1'b1;
            shift_r   <= 8'h00;
            par_ok_r  <= 1'b1;
        end else if (tick_s) begin
            if (state_r == IDLE || state_next_s == IDLE || state_next_s == BREAK)
                os_cnt_r <= 4'd0;
            else
                os_cnt_r <= os_cnt_r + 4'd1;
            if (state_r == START)
                bit_cnt_r <= 3'd0;
            else if (state_r == DATA && os_cnt_r == OS_LAST)
                bit_cnt_r <= bit_cnt_r + 3'd1;
            if (os_cnt_r == SMP_A) smp_a_r <= line_s;
            if (os_cnt_r == SMP_B) smp_b_r <= line_s;
            if (state_r == DATA && os_cnt_r == SMP_C)
                shift_r <= {bit_val_s, shift_r[7:1]};
            if (state_r == PARITY && os_cnt_r == SMP_C)
                par_ok_r <= ((parity8(shift_r) ^ bit_val_s ^ PARITY_ODD) == 1'b0);
        end
    end

    // registered outputs: delivery, handshake, error pulses and busy
    always_ff @(posedge clk_16MHz) begin
        if (!rst_n) begin
            dout_byte  <= 8'h00;
            dout_vld   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err  <= stop_done_s & ~bit_val_s;
            parity_err <= stop_done_s & bit_val_s & ~parity_ok_s;
            overrun    <= deliver_s & dout_vld & ~dout_ack;
            busy       <= (state_next_s != IDLE);
            if (deliver_s) begin
                dout_byte <= shift_r;
                dout_vld  <= 1'b1;
            end else if (dout_vld && dout_ack) begin
                dout_vld  <= 1'b0;
            end
        end
    end

endmodule
